// File: rtl/rr_priority_arbiter.sv
// Registered WIDTH-way arbiter with selectable fixed-priority (MSB highest) or
// round-robin selection. The owner keeps the grant until it releases, drops its
// request or reaches the MAX_HOLD consecutive-cycle limit. Every ownership end
// is followed by one idle cycle before the next arbitration.
module rr_priority_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 16,
    localparam int IDX_W   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             rr_mode,
    input  logic             release_in,
    output logic [WIDTH-1:0] grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             timeout
);

    localparam int HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   grant_q,     grant_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]   last_q,      last_d;
    logic [HOLD_W-1:0]  hold_cnt_q,  hold_cnt_d;
    logic               timeout_q,   timeout_d;

    logic [IDX_W-1:0]   fixed_win;
    logic [IDX_W-1:0]   rr_win;
    logic [IDX_W-1:0]   rr_cand;
    logic [IDX_W-1:0]   winner;

    // Winner candidates: highest set bit, and first set bit descending from last-1.
    always_comb begin
        fixed_win = '0;
        rr_win    = '0;
        rr_cand   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (req[IDX_W'(i)]) fixed_win = IDX_W'(i);
        end
        // Walk from the lowest-priority candidate (last owner) up to last-1 so
        // the final overriding assignment is the highest-priority match.
        for (int k = WIDTH; k >= 1; k--) begin
            rr_cand = IDX_W'((int'(last_q) + WIDTH - k) % WIDTH);
            if (req[rr_cand]) rr_win = rr_cand;
        end
        winner = rr_mode ? rr_win : fixed_win;
    end

    // Next-state and next-output logic for the IDLE/GRANTED ownership FSM.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        last_d      = last_q;
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = GRANTED;
                    grant_d     = WIDTH'(1) << winner;
                    grant_idx_d = winner;
                    last_d      = winner;
                    hold_cnt_d  = HOLD_W'(1);
                end
            end
            GRANTED: begin
                if (release_in || !req[grant_idx_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_W'(MAX_HOLD))) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    timeout_d = 1'b1;
                end else if (hold_cnt_q != {HOLD_W{1'b1}}) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            last_q      <= '0;
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_idx   = grant_idx_q;
    assign timeout     = timeout_q;

endmodule
